// File: rtl/popcnt_frame_accum.sv
// ============================================================================
//  Module      : popcnt_frame_accum
//  Description : Accumulates clamped per-cycle popcounts over fixed-length
//                frames and hands each frame total to a one-deep output buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module popcnt_frame_accum #(
    parameter int          FRAME_LEN = 16,
    parameter int          WIDTH_IN  = 5,
    parameter int          WIDTH_ACC = 9,
    parameter int unsigned THRESH    = 96
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_valid,
    input  logic [WIDTH_IN-1:0]  i_sum,
    output logic                 o_ready,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH_ACC-1:0] o_total,
    output logic                 o_over,
    output logic                 o_err
);

    localparam int                  c_CW      = $clog2(FRAME_LEN);
    localparam logic [c_CW-1:0]     c_LAST    = c_CW'(FRAME_LEN - 1);
    localparam logic [WIDTH_IN-1:0] c_MAX_IN  = WIDTH_IN'(12);

    logic [WIDTH_ACC-1:0] r_acc;
    logic [c_CW-1:0]      r_cnt;

    logic                 w_accept;
    logic                 w_use;
    logic                 w_last;
    logic                 w_done;
    logic                 w_xfer;
    logic                 w_bad;
    logic [WIDTH_IN-1:0]  w_samp;
    logic [WIDTH_ACC:0]   w_sum;
    logic [WIDTH_ACC-1:0] w_sat;

    // Ready depends only on registered state, so i_ready never reaches o_ready.
    assign w_last   = (r_cnt == c_LAST);
    assign o_ready  = ~(o_valid & w_last);
    assign w_accept = i_valid & o_ready;
    assign w_use    = w_accept & ~i_clear;
    assign w_done   = w_use & w_last;
    assign w_xfer   = o_valid & i_ready;

    assign w_bad    = (i_sum > c_MAX_IN);
    assign w_samp   = w_bad ? c_MAX_IN : i_sum;

    // One extra bit catches the carry; the sum then clips to all-ones.
    assign w_sum    = {1'b0, r_acc} + (WIDTH_ACC + 1)'(w_samp);
    assign w_sat    = w_sum[WIDTH_ACC] ? {WIDTH_ACC{1'b1}} : w_sum[WIDTH_ACC-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            o_valid <= 1'b0;
            o_total <= '0;
            o_over  <= 1'b0;
            o_err   <= 1'b0;
        end else begin
            if (i_clear) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_accept) begin
                if (w_last) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_sat;
                    r_cnt <= r_cnt + c_CW'(1);
                end
            end

            if (w_use && w_bad) begin
                o_err <= 1'b1;
            end

            // A completing frame takes priority over draining the buffer.
            if (w_done) begin
                o_total <= w_sat;
                o_over  <= (32'(w_sat) > THRESH);
                o_valid <= 1'b1;
            end else if (w_xfer) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_popcnt_frame_accum.sv
`default_nettype none

module tb_popcnt_frame_accum;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       valid;
    logic [4:0] sum;
    logic       ready;

    logic       o_ready, o_valid, o_over, o_err;
    logic [8:0] o_total;
    logic       s_ready, s_valid, s_over, s_err;
    logic [5:0] s_total;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    popcnt_frame_accum dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clear (clear),
        .i_valid (valid),
        .i_sum   (sum),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .i_ready (ready),
        .o_total (o_total),
        .o_over  (o_over),
        .o_err   (o_err)
    );

    popcnt_frame_accum #(.WIDTH_ACC(6)) dut_sat (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_clear (clear),
        .i_valid (valid),
        .i_sum   (sum),
        .o_ready (s_ready),
        .o_valid (s_valid),
        .i_ready (ready),
        .o_total (s_total),
        .o_over  (s_over),
        .o_err   (s_err)
    );

    typedef struct {
        int first;
        int rest;
        int total;
        int over;
        int sat_total;
        int err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge with o_valid=0 and ready=1; feeds one full frame.
    task automatic do_frame(input int first, input int rest, input int total,
                            input int over, input int sat_total, input int err,
                            input string tag);
        for (int i = 0; i < 16; i++) begin
            valid = 1'b1;
            sum   = 5'((i == 0) ? first : rest);
            @(negedge clk);
        end
        valid = 1'b0;
        check({tag, " valid"},     int'(o_valid), 1);
        check({tag, " total"},     int'(o_total), total);
        check({tag, " over"},      int'(o_over),  over);
        check({tag, " err"},       int'(o_err),   err);
        check({tag, " sat_total"}, int'(s_total), sat_total);
        @(negedge clk);
        check({tag, " valid_pulse"}, int'(o_valid), 0);
    endtask

    initial begin
        vecs[0] = '{7,  7,  112, 1, 63, 0};
        vecs[1] = '{6,  6,  96,  0, 63, 0};
        vecs[2] = '{7,  6,  97,  1, 63, 0};
        vecs[3] = '{0,  0,  0,   0, 0,  0};
        vecs[4] = '{12, 12, 192, 1, 63, 0};
        vecs[5] = '{12, 0,  12,  0, 12, 0};
        vecs[6] = '{31, 0,  12,  0, 12, 1};
        vecs[7] = '{1,  1,  16,  0, 16, 1};

        rst_n = 1'b0;
        clear = 1'b0;
        valid = 1'b0;
        sum   = '0;
        ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst valid", int'(o_valid), 0);
        check("rst total", int'(o_total), 0);
        check("rst over",  int'(o_over),  0);
        check("rst err",   int'(o_err),   0);
        check("rst ready", int'(o_ready), 1);

        for (int v = 0; v < 8; v++) begin
            do_frame(vecs[v].first, vecs[v].rest, vecs[v].total, vecs[v].over,
                     vecs[v].sat_total, vecs[v].err, $sformatf("vec%0d", v));
        end

        // Backpressure: 32 samples of 1 with the consumer stalled.
        ready = 1'b0;
        valid = 1'b1;
        sum   = 5'd1;
        repeat (16) @(negedge clk);
        check("bp first valid", int'(o_valid), 1);
        check("bp first total", int'(o_total), 16);
        check("bp ready mid",   int'(o_ready), 1);
        repeat (15) @(negedge clk);
        check("bp stall ready", int'(o_ready), 0);
        repeat (3) @(negedge clk);
        check("bp held ready", int'(o_ready), 0);
        check("bp held total", int'(o_total), 16);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("bp xfer valid", int'(o_valid), 0);
        check("bp xfer ready", int'(o_ready), 1);
        @(negedge clk);
        valid = 1'b0;
        check("bp second valid", int'(o_valid), 1);
        check("bp second total", int'(o_total), 16);
        check("bp err sticky",   int'(o_err),   1);
        ready = 1'b1;
        @(negedge clk);
        check("bp drained", int'(o_valid), 0);

        // Clear discards the partial frame and the sample on the clear edge.
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1;
            sum   = 5'd12;
            @(negedge clk);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr no valid", int'(o_valid), 0);
        do_frame(2, 2, 32, 0, 32, 1, "clr");

        // Asynchronous reset while a result is held and a frame is partial.
        ready = 1'b0;
        valid = 1'b1;
        sum   = 5'd3;
        repeat (19) @(negedge clk);
        valid = 1'b0;
        check("ar pre valid", int'(o_valid), 1);
        check("ar pre total", int'(o_total), 48);
        #2 rst_n = 1'b0;
        #1;
        check("ar valid", int'(o_valid), 0);
        check("ar total", int'(o_total), 0);
        check("ar over",  int'(o_over),  0);
        check("ar err",   int'(o_err),   0);
        check("ar ready", int'(o_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        do_frame(1, 1, 16, 0, 16, 0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/popcnt_frame_accum.md
# popcnt_frame_accum

Downstream consumer of the 12-input 1-bit adder. Each accepted 5-bit per-cycle popcount is added into a running frame total. After FRAME_LEN accepted samples, the total and a threshold flag are registered into a one-deep output buffer with a valid/ready handshake. The accumulator restarts for the next frame while the previous result waits to be taken.

## Interface
- FRAME_LEN, 16: accepted samples per frame; must be ≥2.
- WIDTH_IN, 5: width of the popcount input. Legal input values are 0..12.
- WIDTH_ACC, 9: width of the accumulator and total.
- THRESH, 96: the over-threshold flag is set when the frame total is strictly greater than THRESH.
- i_clk  input  1  single clock; all logic is rising-edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_clear  input  1  synchronous flush of the partial frame.
- i_valid  input  1  upstream sample valid.
- i_sum  input  WIDTH_IN  popcount sample.
- o_ready  output  1  block can accept a sample this cycle.
- o_valid  output  1  o_total and o_over hold a completed frame.
- i_ready  input  1  downstream takes the result.
- o_total  output  WIDTH_ACC  completed frame total.
- o_over  output  1  o_total > THRESH.
- o_err  output  1  sticky flag: at least one input sample was greater than 12.

## Operation
- A sample is accepted when i_valid && o_ready is high at a rising edge.
- Input clamp: an accepted i_sum greater than 12 is added as 12, and o_err is set. o_err stays set until reset.
- Accumulator arithmetic is unsigned and saturates at 2^WIDTH_ACC-1. It never wraps.
- Sample counter cnt counts 0..FRAME_LEN-1 and increments on each accepted sample.
- An accept with cnt==FRAME_LEN-1 is the last sample of the frame. On that edge:
  - o_total <= acc + clamped sample, saturated;
  - o_over <= that value > THRESH;
  - o_valid <= 1;
  - acc <= 0;
  - cnt <= 0.
- An output transfer happens when o_valid && i_ready is high at a rising edge. Transfer clears o_valid unless a new frame completes on the same edge; in that case the new result loads and o_valid stays 1.
- o_ready = !(o_valid && cnt==FRAME_LEN-1). A last sample stalls only while the previous result is untaken. There is no combinational path from i_ready to o_ready.
- The FSM is derived from (o_valid, cnt):
  - ACCUM: o_valid=0.
  - ACCUM_HELD: o_valid=1 and cnt<FRAME_LEN-1.
  - STALL: o_valid=1 and cnt==FRAME_LEN-1, so o_ready=0.
  - STALL exits to ACCUM on an output transfer, after which the last sample is accepted.
- i_clear at an edge sets acc <= 0 and cnt <= 0, and any sample accepted on that edge is discarded. The output buffer, o_valid and o_err are unaffected.
- o_total and o_over are stable while o_valid=1 and no transfer has occurred.

## Timing
- Reset values: o_valid=0, o_total=0, o_over=0, o_err=0, acc=0, cnt=0. This gives o_ready=1.
- Reset is asynchronous on assertion. Deassertion is sampled on i_clk.
- Reset mid-frame discards both the partial frame and the buffered result.
- Latency: o_valid rises the cycle after the edge that accepts the last sample.
- Back-to-back operation: with i_valid=1 and i_ready=1 continuously, throughput is one sample per cycle with no stalls. o_valid pulses for one cycle every FRAME_LEN cycles.
- i_valid may drop at any cycle. Gaps do not affect cnt or acc.
- i_clear and i_rst_n both active: reset wins.

## Test plan
- Basic frame: reset, then 16 back-to-back samples of value 7 with i_ready=1 -> o_valid for one cycle, o_total=112, o_over=1, o_err=0.
- Below threshold: 16 samples of value 6 (total 96) -> o_total=96, o_over=0. The boundary is exclusive.
- Backpressure stall: i_ready=0, feed 32 samples of value 1 continuously.
  - o_valid=1 with o_total=16 after the first frame.
  - o_ready falls when cnt=15 of the second frame.
  - Raise i_ready for 1 cycle -> first result transfers, the stalled sample is accepted next cycle, and the next o_total=16.
- Clamp and error: one sample of 31 among 15 zeros -> o_total=12, o_err=1. o_err stays 1 through the following frames until i_rst_n=0.
- Clear and reset mid-frame:
  - 5 samples of 12, pulse i_clear, then 16 samples of 2 -> o_total=32.
  - Separately, assert i_rst_n=0 asynchronously mid-frame with o_valid=1 -> all outputs 0 immediately.
- Saturation: WIDTH_ACC=6, FRAME_LEN=16, 16 samples of 12 -> o_total=63, not 192 mod 64=0.
